// File: rtl/usb_desc_pkg.sv
// Shared constants for the EP0 GET_DESCRIPTOR fetch engine: descriptor
// type codes, the fetch FSM state encoding and a small min helper.
package usb_desc_pkg;

  localparam logic [7:0] DT_DEVICE = 8'h01;
  localparam logic [7:0] DT_CONFIG = 8'h02;
  localparam logic [7:0] DT_STRING = 8'h03;
  localparam logic [7:0] DT_QUAL   = 8'h06;
  localparam logic [7:0] DT_OSCFG  = 8'h07;
  localparam logic [7:0] DT_BOS    = 8'h0F;
  localparam logic [7:0] DT_HIDRPT = 8'h22;

  // String descriptor 0 (LANGID table) always holds exactly one language.
  localparam logic [15:0] LANG_LEN = 16'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_IN = 2'd1,
    ST_SEND    = 2'd2,
    ST_STALL   = 2'd3
  } state_t;

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_desc_lookup.sv
// Combinational map from GET_DESCRIPTOR wValue (type/index) and link speed
// to descriptor {base, len, valid, osp}. USB_DESC_BOS_EN enables the BOS entry.
module usb_desc_lookup
  import usb_desc_pkg::*;
(
  input  logic [7:0]  desc_type,
  input  logic [7:0]  desc_index,
  input  logic        hs_mode,
  input  logic        have_strings,
  input  logic [15:0] dev_addr,
  input  logic [15:0] dev_len,
  input  logic [15:0] qual_addr,
  input  logic [15:0] qual_len,
  input  logic [15:0] fscfg_addr,
  input  logic [15:0] fscfg_len,
  input  logic [15:0] hscfg_addr,
  input  logic [15:0] hscfg_len,
  input  logic [15:0] hidrpt_addr,
  input  logic [15:0] hidrpt_len,
  input  logic [15:0] bos_addr,
  input  logic [15:0] bos_len,
  input  logic [15:0] strlang_addr,
  input  logic [15:0] strvendor_addr,
  input  logic [15:0] strvendor_len,
  input  logic [15:0] strproduct_addr,
  input  logic [15:0] strproduct_len,
  input  logic [15:0] strserial_addr,
  input  logic [15:0] strserial_len,
  output logic [15:0] base,
  output logic [15:0] len,
  output logic        valid,
  output logic        osp
);

`ifndef USB_DESC_BOS_EN
  logic unused_bos_s;
  assign unused_bos_s = ^{bos_addr, bos_len};
`endif

  // Select the descriptor entry; anything unmatched answers invalid (STALL).
  always_comb begin
    base  = 16'd0;
    len   = 16'd0;
    valid = 1'b0;
    osp   = 1'b0;
    case (desc_type)
      DT_DEVICE: begin base = dev_addr;    len = dev_len;    valid = 1'b1; end
      DT_QUAL:   begin base = qual_addr;   len = qual_len;   valid = 1'b1; end
      DT_HIDRPT: begin base = hidrpt_addr; len = hidrpt_len; valid = 1'b1; end
      DT_CONFIG: begin
        if (hs_mode) begin base = hscfg_addr; len = hscfg_len; end
        else begin base = fscfg_addr; len = fscfg_len; end
        valid = 1'b1;
      end
      // Other-speed config: the opposite speed's body, byte 1 patched later.
      DT_OSCFG: begin
        if (hs_mode) begin base = fscfg_addr; len = fscfg_len; end
        else begin base = hscfg_addr; len = hscfg_len; end
        valid = 1'b1;
        osp   = 1'b1;
      end
      DT_BOS: begin
`ifdef USB_DESC_BOS_EN
        base  = bos_addr;
        len   = bos_len;
        valid = 1'b1;
`else
        valid = 1'b0;
`endif
      end
      DT_STRING: begin
        if (!have_strings) begin
          valid = 1'b0;
        end else begin
          case (desc_index)
            8'd0: begin base = strlang_addr;    len = LANG_LEN;       valid = 1'b1; end
            8'd1: begin base = strvendor_addr;  len = strvendor_len;  valid = 1'b1; end
            8'd2: begin base = strproduct_addr; len = strproduct_len; valid = 1'b1; end
            8'd3: begin base = strserial_addr;  len = strserial_len;  valid = 1'b1; end
            default: valid = 1'b0;
          endcase
        end
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/usb_desc_fetch.sv
// EP0 descriptor fetch engine: serves GET_DESCRIPTOR data from a descriptor
// ROM in MAX_PKT-sized IN packets, with ZLP and STALL handling.
// Optional feature macro: USB_DESC_BOS_EN (serve BOS descriptor, type 0x0F).
module usb_desc_fetch
  import usb_desc_pkg::*;
#(
  parameter int MAX_PKT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [7:0]  req_type,
  input  logic [7:0]  req_index,
  input  logic [15:0] req_wlength,
  input  logic        hs_mode,
  input  logic        abort,
  input  logic        in_tok,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  output logic        tx_zlp,
  input  logic        tx_ready,
  output logic        stall,
  output logic        busy,
  output logic [15:0] descrom_raddr_o,
  input  logic [7:0]  descrom_rdata_i,
  input  logic [15:0] desc_dev_addr_i,
  input  logic [15:0] desc_dev_len_i,
  input  logic [15:0] desc_qual_addr_i,
  input  logic [15:0] desc_qual_len_i,
  input  logic [15:0] desc_fscfg_addr_i,
  input  logic [15:0] desc_fscfg_len_i,
  input  logic [15:0] desc_hscfg_addr_i,
  input  logic [15:0] desc_hscfg_len_i,
  input  logic [15:0] desc_hidrpt_addr_i,
  input  logic [15:0] desc_hidrpt_len_i,
  input  logic [15:0] desc_bos_addr_i,
  input  logic [15:0] desc_bos_len_i,
  input  logic [15:0] desc_strvendor_addr_i,
  input  logic [15:0] desc_strvendor_len_i,
  input  logic [15:0] desc_strproduct_addr_i,
  input  logic [15:0] desc_strproduct_len_i,
  input  logic [15:0] desc_strserial_addr_i,
  input  logic [15:0] desc_strserial_len_i,
  input  logic [15:0] desc_oscfg_addr_i,
  input  logic [15:0] desc_strlang_addr_i,
  input  logic        desc_have_strings_i
);

  localparam logic [15:0] PKT_MASK = 16'(MAX_PKT - 1);
  localparam logic [6:0]  PKT_LAST = 7'(MAX_PKT - 1);

  state_t      state_r, state_n;
  logic [15:0] base_r, base_n, total_r, total_n, wlen_r, wlen_n, offset_r, offset_n;
  logic [6:0]  pkt_r, pkt_n;
  logic        osp_r, osp_n;
  logic [7:0]  data_r, data_n;
  logic        valid_r, valid_n, last_r, last_n, zlp_r, zlp_n, stall_r, busy_r;
  logic [15:0] lk_base_s, lk_len_s;
  logic        lk_valid_s, lk_osp_s, need_zlp_s, last_at_s;

  usb_desc_lookup u_lookup (
    .desc_type       (req_type),
    .desc_index      (req_index),
    .hs_mode         (hs_mode),
    .have_strings    (desc_have_strings_i),
    .dev_addr        (desc_dev_addr_i),
    .dev_len         (desc_dev_len_i),
    .qual_addr       (desc_qual_addr_i),
    .qual_len        (desc_qual_len_i),
    .fscfg_addr      (desc_fscfg_addr_i),
    .fscfg_len       (desc_fscfg_len_i),
    .hscfg_addr      (desc_hscfg_addr_i),
    .hscfg_len       (desc_hscfg_len_i),
    .hidrpt_addr     (desc_hidrpt_addr_i),
    .hidrpt_len      (desc_hidrpt_len_i),
    .bos_addr        (desc_bos_addr_i),
    .bos_len         (desc_bos_len_i),
    .strlang_addr    (desc_strlang_addr_i),
    .strvendor_addr  (desc_strvendor_addr_i),
    .strvendor_len   (desc_strvendor_len_i),
    .strproduct_addr (desc_strproduct_addr_i),
    .strproduct_len  (desc_strproduct_len_i),
    .strserial_addr  (desc_strserial_addr_i),
    .strserial_len   (desc_strserial_len_i),
    .base            (lk_base_s),
    .len             (lk_len_s),
    .valid           (lk_valid_s),
    .osp             (lk_osp_s)
  );

  // offset_r always names the next byte to fetch; byte 1 of other-speed config is patched.
  assign descrom_raddr_o = (osp_r && (offset_r == 16'd1)) ? desc_oscfg_addr_i : (base_r + offset_r);
  // A short host read that ended exactly on a packet boundary needs a ZLP.
  assign need_zlp_s = (total_r != 16'd0) && ((total_r & PKT_MASK) == 16'd0) && (total_r < wlen_r);
  assign last_at_s  = (offset_r == (total_r - 16'd1));

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state_r;
    base_n   = base_r;
    total_n  = total_r;
    wlen_n   = wlen_r;
    offset_n = offset_r;
    pkt_n    = pkt_r;
    osp_n    = osp_r;
    data_n   = data_r;
    valid_n  = valid_r;
    last_n   = last_r;
    zlp_n    = 1'b0;
    if (abort) begin
      state_n  = ST_IDLE;
      valid_n  = 1'b0;
      last_n   = 1'b0;
      offset_n = 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid && lk_valid_s) begin
            base_n   = lk_base_s;
            total_n  = min16(req_wlength, lk_len_s);
            wlen_n   = req_wlength;
            osp_n    = lk_osp_s;
            offset_n = 16'd0;
            state_n  = ST_WAIT_IN;
          end else if (req_valid) begin
            state_n = ST_STALL;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_WAIT_IN: begin
          if (in_tok && (offset_r == total_r)) begin
            zlp_n   = 1'b1;
            state_n = ST_IDLE;
          end else if (in_tok) begin
            data_n   = descrom_rdata_i;
            valid_n  = 1'b1;
            pkt_n    = 7'd0;
            last_n   = last_at_s;
            offset_n = offset_r + 16'd1;
            state_n  = ST_SEND;
          end else begin
            state_n = ST_WAIT_IN;
          end
        end
        ST_SEND: begin
          if (tx_ready && last_r) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            state_n = ((offset_r < total_r) || need_zlp_s) ? ST_WAIT_IN : ST_IDLE;
          end else if (tx_ready) begin
            data_n   = descrom_rdata_i;
            pkt_n    = pkt_r + 7'd1;
            last_n   = ((pkt_r + 7'd1) == PKT_LAST) || last_at_s;
            offset_n = offset_r + 16'd1;
          end else begin
            state_n = ST_SEND;
          end
        end
        ST_STALL: state_n = ST_STALL;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_n;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r   <= 16'd0;
      total_r  <= 16'd0;
      wlen_r   <= 16'd0;
      offset_r <= 16'd0;
      pkt_r    <= 7'd0;
      osp_r    <= 1'b0;
      data_r   <= 8'd0;
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      zlp_r    <= 1'b0;
      stall_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      base_r   <= base_n;
      total_r  <= total_n;
      wlen_r   <= wlen_n;
      offset_r <= offset_n;
      pkt_r    <= pkt_n;
      osp_r    <= osp_n;
      data_r   <= data_n;
      valid_r  <= valid_n;
      last_r   <= last_n;
      zlp_r    <= zlp_n;
      stall_r  <= (state_n == ST_STALL);
      busy_r   <= (state_n != ST_IDLE);
    end
  end

  assign tx_data  = data_r;
  assign tx_valid = valid_r;
  assign tx_last  = last_r;
  assign tx_zlp   = zlp_r;
  assign stall    = stall_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_usb_desc_fetch.sv
// Directed, table-driven bench for usb_desc_fetch: one instance at MAX_PKT=64
// and one at MAX_PKT=8, sharing a synthetic descriptor ROM.
module tb_usb_desc_fetch;

  localparam logic [15:0] A_DEV = 16'h0000, L_DEV = 16'd18;
  localparam logic [15:0] A_QUAL = 16'h0100, L_QUAL = 16'd10;
  localparam logic [15:0] A_FS = 16'h0200, L_FS = 16'd67;
  localparam logic [15:0] A_HS = 16'h0300, L_HS = 16'd32;
  localparam logic [15:0] A_HID = 16'h0400, L_HID = 16'd50;
  localparam logic [15:0] A_BOS = 16'h0500, L_BOS = 16'd12;
  localparam logic [15:0] A_OSC = 16'h0600, A_LANG = 16'h0700;
  localparam logic [15:0] A_VEN = 16'h0800, L_VEN = 16'd38;
  localparam logic [15:0] A_PRD = 16'h0900, L_PRD = 16'd32;
  localparam logic [15:0] A_SER = 16'h0A00, L_SER = 16'd16;

  typedef struct {
    int          sel;
    logic [7:0]  t;
    logic [7:0]  idx;
    logic [15:0] wl;
    logic        hs;
    logic        hstr;
    logic        exp_stall;
    logic [15:0] base;
    int          total;
    logic        osp;
    logic        zlp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, in_tok, tx_ready, abort, hs_mode, have_str;
  logic [7:0]  req_type, req_index;
  logic [15:0] req_wlength;
  int          sel;
  logic        rv [2];
  logic        it [2];
  logic        tr [2];
  logic [7:0]  txd [2];
  logic        txv [2];
  logic        txl [2];
  logic        txz [2];
  logic        stl [2];
  logic        bsy [2];
  logic [15:0] ra [2];
  logic [7:0]  rd [2];
  int          n_chk = 0;
  int          n_fail = 0;
  vec_t        vecs [15];

  function automatic logic [7:0] romf(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign rv[g] = req_valid && (sel == g);
    assign it[g] = in_tok && (sel == g);
    assign tr[g] = tx_ready && (sel == g);
    assign rd[g] = romf(ra[g]);
    usb_desc_fetch #(.MAX_PKT((g == 0) ? 64 : 8)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[g]), .req_type(req_type),
      .req_index(req_index), .req_wlength(req_wlength), .hs_mode(hs_mode),
      .abort(abort), .in_tok(it[g]), .tx_data(txd[g]), .tx_valid(txv[g]),
      .tx_last(txl[g]), .tx_zlp(txz[g]), .tx_ready(tr[g]), .stall(stl[g]),
      .busy(bsy[g]), .descrom_raddr_o(ra[g]), .descrom_rdata_i(rd[g]),
      .desc_dev_addr_i(A_DEV), .desc_dev_len_i(L_DEV),
      .desc_qual_addr_i(A_QUAL), .desc_qual_len_i(L_QUAL),
      .desc_fscfg_addr_i(A_FS), .desc_fscfg_len_i(L_FS),
      .desc_hscfg_addr_i(A_HS), .desc_hscfg_len_i(L_HS),
      .desc_hidrpt_addr_i(A_HID), .desc_hidrpt_len_i(L_HID),
      .desc_bos_addr_i(A_BOS), .desc_bos_len_i(L_BOS),
      .desc_strvendor_addr_i(A_VEN), .desc_strvendor_len_i(L_VEN),
      .desc_strproduct_addr_i(A_PRD), .desc_strproduct_len_i(L_PRD),
      .desc_strserial_addr_i(A_SER), .desc_strserial_len_i(L_SER),
      .desc_oscfg_addr_i(A_OSC), .desc_strlang_addr_i(A_LANG),
      .desc_have_strings_i(have_str)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue_req(input vec_t v);
    sel = v.sel; req_type = v.t; req_index = v.idx; req_wlength = v.wl;
    hs_mode = v.hs; have_str = v.hstr;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Consume one packet of pk bytes starting at byte index sent, ready toggling.
  task automatic take_packet(input vec_t v, input int sent, input int pk);
    int got = 0;
    int cyc = 0;
    logic [15:0] a;
    in_tok = 1'b1;
    @(negedge clk);
    in_tok = 1'b0;
    while (got < pk && cyc < 400) begin
      a = (v.osp && (sent + got == 1)) ? A_OSC : v.base + 16'(sent + got);
      check("tx_valid", 32'(txv[v.sel]), 32'd1);
      check("tx_data", 32'(txd[v.sel]), 32'(romf(a)));
      check("tx_last", 32'(txl[v.sel]), 32'(got == pk - 1));
      tx_ready = ((cyc % 3) != 2);
      @(negedge clk);
      if (tx_ready) got++;
      cyc++;
    end
    tx_ready = 1'b0;
    check("pkt_bytes", 32'(got), 32'(pk));
    check("valid_after_pkt", 32'(txv[v.sel]), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int sent = 0;
    int mp = (v.sel == 0) ? 64 : 8;
    int pk;
    issue_req(v);
    check("busy_req", 32'(bsy[v.sel]), 32'd1);
    check("stall_req", 32'(stl[v.sel]), 32'(v.exp_stall));
    if (v.exp_stall) begin
      in_tok = 1'b1;
      @(negedge clk);
      in_tok = 1'b0;
      repeat (2) @(negedge clk);
      check("stall_held", 32'(stl[v.sel]), 32'd1);
      check("stall_noval", 32'(txv[v.sel]), 32'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("stall_abort", 32'(stl[v.sel]), 32'd0);
      check("busy_abort", 32'(bsy[v.sel]), 32'd0);
    end else begin
      check("wait_noval", 32'(txv[v.sel]), 32'd0);
      while (sent < v.total) begin
        pk = (v.total - sent < mp) ? v.total - sent : mp;
        take_packet(v, sent, pk);
        sent += pk;
        if (sent < v.total || v.zlp) check("busy_between", 32'(bsy[v.sel]), 32'd1);
      end
      if (v.zlp) begin
        in_tok = 1'b1;
        @(negedge clk);
        in_tok = 1'b0;
        check("zlp_pulse", 32'(txz[v.sel]), 32'd1);
        check("zlp_noval", 32'(txv[v.sel]), 32'd0);
        @(negedge clk);
      end
      check("zlp_off", 32'(txz[v.sel]), 32'd0);
      check("busy_done", 32'(bsy[v.sel]), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 8'h01, 8'd0, 16'd64,  1'b0, 1'b1, 1'b0, A_DEV,  18, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'h02, 8'd0, 16'd255, 1'b0, 1'b1, 1'b0, A_FS,   67, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'h07, 8'd0, 16'd255, 1'b1, 1'b1, 1'b0, A_FS,   67, 1'b1, 1'b0};
    vecs[3]  = '{1, 8'h02, 8'd0, 16'd9,   1'b1, 1'b1, 1'b0, A_HS,   9,  1'b0, 1'b0};
    vecs[4]  = '{1, 8'h03, 8'd1, 16'd38,  1'b0, 1'b1, 1'b0, A_VEN,  38, 1'b0, 1'b0};
    vecs[5]  = '{1, 8'h03, 8'd2, 16'd40,  1'b0, 1'b1, 1'b0, A_PRD,  32, 1'b0, 1'b1};
    vecs[6]  = '{1, 8'h03, 8'd0, 16'd255, 1'b0, 1'b1, 1'b0, A_LANG, 4,  1'b0, 1'b0};
    vecs[7]  = '{1, 8'h03, 8'd5, 16'd64,  1'b0, 1'b1, 1'b1, 16'h0,  0,  1'b0, 1'b0};
    vecs[8]  = '{1, 8'h03, 8'd1, 16'd64,  1'b0, 1'b0, 1'b1, 16'h0,  0,  1'b0, 1'b0};
`ifdef USB_DESC_BOS_EN
    vecs[9]  = '{0, 8'h0F, 8'd0, 16'd64,  1'b0, 1'b1, 1'b0, A_BOS,  12, 1'b0, 1'b0};
`else
    vecs[9]  = '{0, 8'h0F, 8'd0, 16'd64,  1'b0, 1'b1, 1'b1, 16'h0,  0,  1'b0, 1'b0};
`endif
    vecs[10] = '{0, 8'h05, 8'd0, 16'd64,  1'b0, 1'b1, 1'b1, 16'h0,  0,  1'b0, 1'b0};
    vecs[11] = '{0, 8'h01, 8'd0, 16'd0,   1'b0, 1'b1, 1'b0, A_DEV,  0,  1'b0, 1'b1};
    vecs[12] = '{1, 8'h22, 8'd0, 16'd16,  1'b0, 1'b1, 1'b0, A_HID,  16, 1'b0, 1'b0};
    vecs[13] = '{0, 8'h07, 8'd0, 16'd100, 1'b0, 1'b1, 1'b0, A_HS,   32, 1'b1, 1'b0};
    vecs[14] = '{1, 8'h06, 8'd0, 16'd10,  1'b0, 1'b1, 1'b0, A_QUAL, 10, 1'b0, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; in_tok = 1'b0; tx_ready = 1'b0; abort = 1'b0;
    hs_mode = 1'b0; have_str = 1'b1; req_type = 8'd0; req_index = 8'd0;
    req_wlength = 16'd0; sel = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", 32'(txv[d]), 32'd0);
      check("rst_last", 32'(txl[d]), 32'd0);
      check("rst_zlp", 32'(txz[d]), 32'd0);
      check("rst_stall", 32'(stl[d]), 32'd0);
      check("rst_busy", 32'(bsy[d]), 32'd0);
      check("rst_data", 32'(txd[d]), 32'd0);
      check("rst_raddr", 32'(ra[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Abort mid-packet; a request arriving while busy must be ignored.
    issue_req(vecs[0]);
    req_type = 8'h06;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    in_tok = 1'b1;
    @(negedge clk);
    in_tok = 1'b0;
    check("ignored_req_data", 32'(txd[0]), 32'(romf(A_DEV)));
    for (int c = 0; c < 5; c++) begin
      tx_ready = c[0];
      @(negedge clk);
    end
    check("mid_valid", 32'(txv[0]), 32'd1);
    abort = 1'b1; tx_ready = 1'b1; in_tok = 1'b1;
    @(negedge clk);
    abort = 1'b0; tx_ready = 1'b0; in_tok = 1'b0;
    check("abort_valid", 32'(txv[0]), 32'd0);
    check("abort_busy", 32'(bsy[0]), 32'd0);
    check("abort_last", 32'(txl[0]), 32'd0);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_desc_fetch.md
USB_DESC_FETCH -- requirements
Module: usb_desc_fetch

Interface
REQ-001 SHALL have parameter MAX_PKT, default 64, meaning the EP0 max packet size in bytes (8/16/32/64).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, a one-cycle pulse carrying a decoded GET_DESCRIPTOR request.
REQ-005 SHALL have ports req_type (8), req_index (8) and req_wlength (16), all inputs: wValue high byte, wValue low byte and wLength.
REQ-006 SHALL have port hs_mode, input, 1, high-speed link active.
REQ-007 SHALL have port abort, input, 1, a new SETUP token arrived.
REQ-008 SHALL have port in_tok, input, 1, a one-cycle IN-token pulse requesting the next data packet.
REQ-009 SHALL have outputs tx_data (8), tx_valid (1), tx_last (1) and tx_zlp (1), plus input tx_ready (1): the byte stream to the packet transmitter.
REQ-010 SHALL have outputs stall (1), answer STALL, and busy (1), transfer in progress.
REQ-011 SHALL have output descrom_raddr_o (16) and input descrom_rdata_i (8), a combinational descriptor ROM read port.
REQ-012 SHALL have 16-bit inputs desc_{dev,qual,fscfg,hscfg,hidrpt,bos,strvendor,strproduct,strserial}_addr_i / _len_i, 16-bit inputs desc_oscfg_addr_i and desc_strlang_addr_i, and 1-bit input desc_have_strings_i.

Function
REQ-013 SHALL implement states IDLE, WAIT_IN, SEND and STALL.
REQ-014 On req_valid in IDLE, SHALL latch base address and total = min(req_wlength, desc_len), then go to WAIT_IN, or to STALL if the type is unsupported.
REQ-015 SHALL map req_type as follows: 0x01 dev; 0x06 qual; 0x02 hs_mode ? hscfg : fscfg; 0x07 hs_mode ? fscfg : hscfg; 0x22 hidrpt; 0x0F bos; 0x03 string.
REQ-016 For string type, index 0/1/2/3 SHALL select lang (length fixed at 4) / vendor / product / serial; index >3 or desc_have_strings_i=0 SHALL go to STALL.
REQ-017 For type 0x07, the byte at offset 1 SHALL be read from desc_oscfg_addr_i; every other byte SHALL be read from base+offset.
REQ-018 descrom_raddr_o SHALL equal base+offset (16-bit, wrap ignored); offset SHALL start at 0 per request.
REQ-019 In WAIT_IN, in_tok SHALL load tx_data from the ROM and assert tx_valid on the next cycle; then go to SEND.
REQ-020 A byte transfers on tx_valid&&tx_ready; tx_data and tx_valid SHALL hold while tx_ready=0; the next byte SHALL follow with no bubble.
REQ-021 tx_last SHALL accompany the byte that ends a packet: pkt_cnt==MAX_PKT-1 or sent==total-1.
REQ-022 After tx_last handshakes, SHALL go to WAIT_IN if sent<total, else to IDLE.
REQ-023 When total is a nonzero multiple of MAX_PKT and total<req_wlength, one further in_tok SHALL yield a single-cycle tx_zlp pulse (tx_valid=0), then IDLE.
REQ-024 total==0 SHALL answer the first in_tok with tx_zlp, then IDLE.
REQ-025 In STALL, stall=1; abort SHALL return to IDLE.
REQ-026 abort in any state SHALL win over all other inputs and return to IDLE next cycle, dropping tx_valid; req_valid outside IDLE SHALL be ignored.
REQ-027 busy SHALL be 1 in every state except IDLE.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, tx_valid=tx_last=tx_zlp=stall=busy=0, tx_data=0, offset=0 and descrom_raddr_o=0.

Configuration
REQ-029 With USB_DESC_BOS_EN defined, type 0x0F SHALL be served from bos; without it, type 0x0F SHALL go to STALL and the bos inputs SHALL be unused.

Structure
REQ-030 Package usb_desc_pkg SHALL hold the descriptor-type constants (0x01, 0x02, 0x03, 0x06, 0x07, 0x0F, 0x22) and the state enum.
REQ-031 A single sub-module, usb_desc_lookup, SHALL be a combinational mapping from type/index/hs_mode to {base, len, valid, osp}.

Verification
REQ-032 dev, wLength=64, MAX_PKT=64 -> 18 bytes from addr 0..17, tx_last on the 18th, then IDLE.
REQ-033 fscfg, len 67, wLength=255, MAX_PKT=64 -> packets of 64 and 3 bytes, each started by in_tok, with no ZLP.
REQ-034 Type 0x07 with hs_mode=1 -> byte1=ROM[oscfg_addr], all other bytes from fscfg.
REQ-035 Vendor string, len 38, wLength=38, MAX_PKT=8 -> five packets of 8/8/8/8/6 bytes, no ZLP; with wLength=40 and len 32 -> a ZLP after four packets.
REQ-036 String index 5, or desc_have_strings_i=0 -> stall=1 until abort.
REQ-037 abort mid-packet with tx_ready toggling -> tx_valid=0 next cycle and IDLE; a following dev request succeeds.
